// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and default width shared by the muldiv_seq block
package muldiv_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAR = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_REM = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/muldiv_barrel.sv
// muldiv_barrel: combinational SHL/SHR/SAR of a by amt (ports: a, amt, op in; y out)
module muldiv_barrel
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] sar;
  always_comb begin
    // kept as its own assignment so the shift stays signed (arithmetic)
    sar = $signed(a) >>> amt;
    y = op == OP_SHL ? a << amt : op == OP_SAR ? sar : a >> amt;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential shift/multiply/divide unit
// ports: clk, rst (async active-low), start/op/mode/a/b request, ld/ld_data direct result load,
//        result/hi held outputs, busy stall, done and dbz single-cycle pulses
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod;
  logic [WIDTH-1:0] opnd, mag_a, mag_b, sh_y, quo, rem, fix_res;
  logic [WIDTH:0] sum, r, diff;
  logic [2:0] op_r;
  logic neg_q, neg_r, sa, sb, accept, is_div, is_shift, is_long, is_dbz, last;

  muldiv_barrel #(.WIDTH(WIDTH), .SHW(SHW)) u_barrel (
    .a(a),
    .amt(b[SHW-1:0]),
    .op(op),
    .y(sh_y)
  );

  always_comb begin
    busy = state != S_IDLE;
    accept = start && !busy;
    is_div = op == OP_DIV || op == OP_REM;
    is_shift = op == OP_SHL || op == OP_SHR || op == OP_SAR;
    is_dbz = is_div && b == '0;
    is_long = op == OP_MUL || (is_div && b != '0);
    last = cnt == CW'(WIDTH - 1);
    state_nxt = state == S_IDLE ? (accept && is_long ? S_RUN : S_IDLE)
              : state == S_RUN  ? (last ? S_FIX : S_RUN)
              : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;

  always_comb begin
    sa = mode && a[WIDTH-1];
    sb = mode && b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    // shift-add: acc = {partial product, remaining multiplier bits}
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_mul = {sum, acc[WIDTH-1:1]};
    // restoring divide: acc = {partial remainder, dividend/quotient bits}
    r = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = r - {1'b0, opnd};
    acc_div = diff[WIDTH] ? {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_res = op_r == OP_MUL ? prod[WIDTH-1:0] : op_r == OP_DIV ? quo : rem;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      op_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
      hi <= '0;
      done <= 1'b0;
      dbz <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz <= 1'b0;
      if (ld && !busy) result <= ld_data;
      if (accept) begin
        op_r <= op;
        acc <= {{WIDTH{1'b0}}, mag_a};
        opnd <= mag_b;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        cnt <= '0;
        done <= !is_long;
        dbz <= is_dbz;
        if (is_shift) result <= sh_y;
        if (is_dbz) result <= op == OP_DIV ? '1 : a;
      end
      if (state == S_RUN) begin
        acc <= op_r == OP_MUL ? acc_mul : acc_div;
        cnt <= cnt + CW'(1);
      end
      if (state == S_FIX) begin
        result <= fix_res;
        if (op_r == OP_MUL) hi <= prod[2*WIDTH-1:WIDTH];
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table, corner sequences and random ops against an arithmetic model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst, start, mode, ld;
  logic [2:0] op;
  logic [15:0] a, b, ld_data, result, hi;
  logic busy, done, dbz;
  int checks = 0;
  int errors = 0;
  logic [15:0] mres, mhi;

  typedef struct {
    logic [2:0] op;
    logic mode;
    logic [15:0] a, b, res, hi;
    logic dbz;
    int cyc;
  } vec_t;
  vec_t tbl[15];

  muldiv_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .mode(mode), .a(a), .b(b),
    .ld(ld), .ld_data(ld_data), .result(result), .hi(hi), .busy(busy),
    .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic m, input logic [15:0] x, y,
                                inout logic [15:0] mr, mh, output logic md, output int mc);
    longint sx, sy, q, rm;
    logic [63:0] p;
    logic signed [15:0] sv;
    sx = m ? longint'($signed(x)) : longint'(x);
    sy = m ? longint'($signed(y)) : longint'(y);
    sv = x;
    md = 1'b0;
    mc = 1;
    case (o)
      3'd0: mr = x << y[3:0];
      3'd1: mr = x >> y[3:0];
      3'd2: mr = sv >>> y[3:0];
      3'd3: begin
        p = sx * sy;
        mr = p[15:0];
        mh = p[31:16];
        mc = 18;
      end
      3'd4, 3'd5: begin
        if (y == 16'd0) begin
          md = 1'b1;
          mr = o == 3'd4 ? 16'hFFFF : x;
        end else begin
          q = sx / sy;
          rm = sx % sy;
          p = o == 3'd4 ? q : rm;
          mr = p[15:0];
          mc = 18;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic m, input logic [15:0] x, y,
                       output logic [15:0] gr, gh, output logic gd, output int gc);
    @(negedge clk);
    op = o; mode = m; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    gc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        gc = k;
        break;
      end
    end
    gr = result; gh = hi; gd = dbz;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] gr, gh, x, y;
    logic gd, md, m;
    logic [2:0] o;
    int gc, mc, ndone, first_k;
    rst = 1'b0; start = 1'b0; op = '0; mode = 1'b0; a = '0; b = '0; ld = 1'b0; ld_data = '0;
    tbl[0]  = '{3'd3, 1'b0, 16'd300,  16'd500,  16'h49F0, 16'h0002, 1'b0, 18};
    tbl[1]  = '{3'd4, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'h0000, 1'b0, 18};
    tbl[2]  = '{3'd5, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 18};
    tbl[3]  = '{3'd4, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
    tbl[4]  = '{3'd5, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 18};
    tbl[5]  = '{3'd4, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1};
    tbl[6]  = '{3'd5, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1};
    tbl[7]  = '{3'd2, 1'b0, 16'h8000, 16'd3,    16'hF000, 16'h0000, 1'b0, 1};
    tbl[8]  = '{3'd1, 1'b0, 16'h8000, 16'd3,    16'h1000, 16'h0000, 1'b0, 1};
    tbl[9]  = '{3'd0, 1'b0, 16'h0001, 16'd15,   16'h8000, 16'h0000, 1'b0, 1};
    tbl[10] = '{3'd0, 1'b0, 16'h1234, 16'd0,    16'h1234, 16'h0000, 1'b0, 1};
    tbl[11] = '{3'd3, 1'b1, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 1'b0, 18};
    tbl[12] = '{3'd4, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 18};
    tbl[13] = '{3'd3, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 18};
    tbl[14] = '{3'd6, 1'b0, 16'h5555, 16'h0003, 16'h0001, 16'h0000, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_hi", {16'd0, hi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    rst = 1'b1;

    @(negedge clk);
    ld = 1'b1; ld_data = 16'hBEEF;
    @(posedge clk);
    #1 ld = 1'b0;
    @(negedge clk);
    chk("ld_idle", {16'd0, result}, 32'h0000BEEF);

    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i].op, tbl[i].mode, tbl[i].a, tbl[i].b, gr, gh, gd, gc);
      chk($sformatf("vec%0d_res", i), {16'd0, gr}, {16'd0, tbl[i].res});
      chk($sformatf("vec%0d_cyc", i), gc, tbl[i].cyc);
      chk($sformatf("vec%0d_dbz", i), {31'd0, gd}, {31'd0, tbl[i].dbz});
      if (tbl[i].op == 3'd3) chk($sformatf("vec%0d_hi", i), {16'd0, gh}, {16'd0, tbl[i].hi});
    end

    // reset in the middle of a multiply
    @(negedge clk);
    op = 3'd3; mode = 1'b0; a = 16'd300; b = 16'd500; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_hi", {16'd0, hi}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1; op = 3'd0; a = 16'h0003; b = 16'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; first_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("post_rst_done_count", ndone, 1);
    chk("post_rst_first_cyc", first_k, 1);
    chk("post_rst_result", {16'd0, result}, 32'h0000000C);

    // start and ld while busy are ignored; start in the done cycle is accepted
    @(negedge clk);
    op = 3'd3; mode = 1'b0; a = 16'd3; b = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; op = 3'd0; a = 16'hFFFF; b = 16'd1; ld = 1'b1; ld_data = 16'h1111;
      end
      if (k == 4) begin
        start = 1'b0; ld = 1'b0;
      end
      if (k == 6) begin
        chk("busy_ld_ignored", {16'd0, result}, 32'h0000000C);
        chk("busy_high", {31'd0, busy}, 32'd1);
      end
      if (done) begin
        first_k = k;
        break;
      end
    end
    chk("busy_mul_cyc", first_k, 18);
    chk("busy_mul_res", {16'd0, result}, 32'd12);
    chk("busy_mul_hi", {16'd0, hi}, 32'd0);
    chk("done_cycle_busy", {31'd0, busy}, 32'd0);
    op = 3'd1; a = 16'h00F0; b = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_res", {16'd0, result}, 32'h0000000F);

    mres = 16'h000F; mhi = 16'h0000;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      m = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = $urandom_range(0, 5) == 0 ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 9) == 0) x = 16'h8000;
      if ($urandom_range(0, 9) == 0) y = 16'hFFFF;
      model(o, m, x, y, mres, mhi, md, mc);
      do_op(o, m, x, y, gr, gh, gd, gc);
      chk($sformatf("rnd%0d_op%0d_res", i, o), {16'd0, gr}, {16'd0, mres});
      chk($sformatf("rnd%0d_op%0d_hi", i, o), {16'd0, gh}, {16'd0, mhi});
      chk($sformatf("rnd%0d_op%0d_dbz", i, o), {31'd0, gd}, {31'd0, md});
      chk($sformatf("rnd%0d_op%0d_cyc", i, o), gc, mc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
